mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV32 pipeline. It holds at most one transaction in flight and gives data priority over fetch, with a bounded-streak fairness rule. It drives per-stage stall signals and returns read data with a one-cycle done pulse. A watchdog aborts memory accesses that never complete.

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified instruction/data memory port between the IF stage
// (fetch) and the MEM stage (load/store). At most one access is in flight.
// Data wins over fetch, except that a waiting fetch is forced through after
// MAX_D_STREAK consecutive data grants. A watchdog aborts accesses whose
// ack never arrives and completes them with a NOP (fetch) or zero (data).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_done)
//   if_rdata/if_done      fetched word and its one-cycle completion pulse
//   d_ctrl/d_addr/d_wdata data request: 10 read, 01 write, 00/11 none
//   d_rdata/d_done        load data and its one-cycle completion pulse
//   stall_if/stall_mem    combinational per-stage stalls
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack     memory response
//   timeout               sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic [1:0]  d_ctrl,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DATA  = 2'b10
  } state_t;

  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  state_t      state_q;
  logic [3:0]  streak_q;
  logic [7:0]  wait_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        timeout_q;

  logic d_rd_s;
  logic d_wr_s;
  logic d_pend_s;
  logic can_grant_s;
  logic grant_data_s;
  logic grant_fetch_s;

  assign d_rd_s   = (d_ctrl == 2'b10);
  assign d_wr_s   = (d_ctrl == 2'b01);
  assign d_pend_s = d_rd_s | d_wr_s;

  // No grant in the done cycle: the finishing requester still holds its
  // request, and this also enforces the 3-cycle grant spacing.
  assign can_grant_s = (state_q == ST_IDLE) & ~if_done_q & ~d_done_q;

  // Grant decision: data first unless a waiting fetch has hit the streak cap.
  always_comb begin
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    if (can_grant_s) begin
      if (d_pend_s && !(if_req && (streak_q == STREAK_MAX))) begin
        grant_data_s = 1'b1;
      end else if (if_req) begin
        grant_fetch_s = 1'b1;
      end else begin
        grant_fetch_s = 1'b0;
      end
    end else begin
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
    end
  end

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= 4'd0;
      wait_q      <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_data_s) begin
            state_q     <= ST_DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_wr_s;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wr_s ? d_wdata : 32'd0;
            wait_q      <= 8'd0;
            // Only count data grants that make a fetch wait.
            if (!if_req) begin
              streak_q <= 4'd0;
            end else if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + 4'd1;
            end else begin
              streak_q <= streak_q;
            end
          end else if (grant_fetch_s) begin
            state_q     <= ST_FETCH;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= 32'd0;
            wait_q      <= 8'd0;
            streak_q    <= 4'd0;
          end else if (!if_req) begin
            streak_q <= 4'd0;
          end else begin
            streak_q <= streak_q;
          end
        end
        ST_FETCH, ST_DATA: begin
          // An ack on the watchdog's last cycle still wins.
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == ST_FETCH) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= mem_we_q ? 32'd0 : mem_rdata;
              d_done_q  <= 1'b1;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            timeout_q <= 1'b1;
            if (state_q == ST_FETCH) begin
              if_rdata_q <= NOP_INSN;
              if_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= 32'd0;
              d_done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign timeout   = timeout_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = d_pend_s & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for mem_port_arbiter: a table of single transactions plus
// hand-written conflict / streak / illegal-ctrl / reset-abort sequences.
// Expected grants and completions are queued when stimulus is driven and
// checked by a negedge monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int TO = 16;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [1:0]  d_ctrl;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO), .MAX_D_STREAK(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout(timeout)
  );

  typedef struct {
    logic [1:0]  kind;      // 0 fetch, 1 read, 2 write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rd;    // value the memory returns
    int          ack_wait;  // wait cycles before ack, -1 = never
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic        is_fetch;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sb_t;

  int   n_vec = 0;
  int   n_err = 0;
  sb_t  exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic sb_t mk_sb(input logic f, input logic [31:0] a, input logic we,
                                input logic [31:0] wd, input logic [31:0] rd);
    sb_t e;
    e.is_fetch = f; e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // Scoreboard monitor: memory request contents and completion data.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (mem_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_grant_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("req_addr", mem_addr, exp_q[0].addr);
          chk("req_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
          chk("req_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (if_done === 1'b1 || d_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_done_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("done_kind", {31'd0, if_done}, {31'd0, e.is_fetch});
          chk("done_exclusive", {31'd0, if_done & d_done}, 32'd0);
          chk("done_rdata", e.is_fetch ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  task automatic idle_inputs;
    if_req = 1'b0; if_addr = 32'd0; d_ctrl = 2'b00; d_addr = 32'd0;
    d_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    chk({tag, "_d_done"}, {31'd0, d_done}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int wait_cnt;
    int first_c;
    bit done_seen;
    tick;
    exp_q.push_back(mk_sb(v.kind == 2'd0, v.addr, v.exp_we, v.exp_wdata, v.exp_rdata));
    mem_rdata = v.mem_rd;
    mem_ack   = 1'b0;
    case (v.kind)
      2'd0:    begin if_req = 1'b1; if_addr = v.addr; end
      2'd1:    begin d_ctrl = 2'b10; d_addr = v.addr; d_wdata = v.wdata; end
      default: begin d_ctrl = 2'b01; d_addr = v.addr; d_wdata = v.wdata; end
    endcase
    #1;
    chk({tag, "_stall"}, {31'd0, (v.kind == 2'd0) ? stall_if : stall_mem}, 32'd1);
    wait_cnt = 0; first_c = -1; done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      tick;
      if (if_done || d_done) begin
        done_seen = 1'b1;
        chk({tag, "_stall_rel"}, {31'd0, stall_if | stall_mem}, 32'd0);
        chk({tag, "_req_cycles"}, wait_cnt, (v.ack_wait < 0) ? 16 : v.ack_wait + 1);
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, v.exp_to});
        if_req = 1'b0; d_ctrl = 2'b00; mem_ack = 1'b0;
      end else if (mem_req) begin
        if (first_c < 0) first_c = c;
        mem_ack = (v.ack_wait >= 0) && (wait_cnt == v.ack_wait);
        wait_cnt++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    chk({tag, "_latency"}, first_c, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int dd, fd, ng, nd, last_g;
    bit prev;
    bit exp_f[6];

    vecs[0] = '{2'd0, 32'h0000_0100, 32'd0, 32'h0050_0093, 0, 1'b0, 32'd0, 32'h0050_0093, 1'b0};
    vecs[1] = '{2'd1, 32'h0000_2000, 32'd0, 32'hCAFE_F00D, 0, 1'b0, 32'd0, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{2'd2, 32'h0000_3004, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0};
    vecs[3] = '{2'd0, 32'h0000_0104, 32'd0, 32'h00A0_0113, 2, 1'b0, 32'd0, 32'h00A0_0113, 1'b0};
    vecs[4] = '{2'd1, 32'h0000_2010, 32'h0000_0055, 32'h0BAD_BEEF, 1, 1'b0, 32'd0, 32'h0BAD_BEEF, 1'b0};
    vecs[5] = '{2'd1, 32'h0000_2020, 32'd0, 32'h0000_0077, 15, 1'b0, 32'd0, 32'h0000_0077, 1'b0};
    vecs[6] = '{2'd0, 32'h0000_0500, 32'd0, 32'hFFFF_FFFF, -1, 1'b0, 32'd0, 32'h0000_0013, 1'b1};
    vecs[7] = '{2'd1, 32'h0000_2030, 32'd0, 32'hFFFF_FFFF, -1, 1'b0, 32'd0, 32'd0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    tick; tick;
    check_reset_vals("por");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout flag is sticky across idle cycles.
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("timeout_sticky", {31'd0, timeout}, 32'd1);
    end

    // Reset in cycle 2 of a read: abandon, no done, all outputs cleared.
    exp_q.push_back(mk_sb(1'b0, 32'h0000_2800, 1'b0, 32'd0, 32'd0));
    d_ctrl = 2'b10; d_addr = 32'h0000_2800; mem_ack = 1'b0;
    tick;
    chk("rst_mid_req_up", {31'd0, mem_req}, 32'd1);
    tick;
    reset = 1'b1;
    tick;
    check_reset_vals("rst_mid");
    d_ctrl = 2'b00;
    tick;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_mid_no_done", {31'd0, d_done | mem_req}, 32'd0);
    end

    // Conflict: data wins, fetch done 3 cycles after d_done; ack held high.
    exp_q.push_back(mk_sb(1'b0, 32'h0000_2000, 1'b0, 32'd0, 32'h00C0_FFEE));
    exp_q.push_back(mk_sb(1'b1, 32'h0000_0200, 1'b0, 32'd0, 32'h00C0_FFEE));
    mem_rdata = 32'h00C0_FFEE; mem_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_ctrl = 2'b10; d_addr = 32'h0000_2000; d_wdata = 32'd0;
    dd = -1; fd = -1;
    for (int c = 0; c < 30 && fd < 0; c++) begin
      tick;
      if (d_done) begin
        dd = c; d_ctrl = 2'b00;
        chk("cf_loser_stalled", {31'd0, stall_if}, 32'd1);
      end
      if (if_done) begin
        fd = c; if_req = 1'b0;
      end
    end
    chk("cf_data_done_cycle", dd, 1);
    chk("cf_fetch_gap", fd - dd, 3);
    mem_ack = 1'b0;
    tick;

    // Streak: fetch held, data back-to-back -> D D D D F D.
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (exp_f[i]) exp_q.push_back(mk_sb(1'b1, 32'h0000_0300, 1'b0, 32'd0, 32'hA5A5_0001));
      else          exp_q.push_back(mk_sb(1'b0, 32'h0000_2400, 1'b0, 32'd0, 32'hA5A5_0001));
    end
    mem_rdata = 32'hA5A5_0001; mem_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_ctrl = 2'b10; d_addr = 32'h0000_2400;
    ng = 0; nd = 0; last_g = -1; prev = 1'b0;
    for (int c = 0; c < 100 && nd < 6; c++) begin
      tick;
      if (mem_req && !prev && ng < 6) begin
        chk($sformatf("stk_grant%0d_fetch", ng), {31'd0, mem_addr == 32'h0000_0300}, {31'd0, exp_f[ng]});
        if (ng > 0) chk("stk_spacing", c - last_g, 3);
        last_g = c;
        ng++;
      end
      prev = mem_req;
      if (if_done) begin if_req = 1'b0; nd++; end
      if (d_done) begin nd++; if (nd == 6) d_ctrl = 2'b00; end
    end
    chk("stk_all_done", nd, 6);
    mem_ack = 1'b0;
    tick;

    // d_ctrl == 11 is never granted and never stalls; ack in IDLE ignored.
    d_ctrl = 2'b11; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("ctl11_no_req", {31'd0, mem_req}, 32'd0);
      chk("ctl11_no_stall", {31'd0, stall_mem}, 32'd0);
      chk("ctl11_no_done", {31'd0, d_done | if_done}, 32'd0);
    end
    idle_inputs();
    tick;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
